// File: rtl/hs_mem_ctrl_pkg.sv
// Shared types for the handshake RAM front-end: controller state encoding
// and a helper for deriving address widths from entry counts.
package hs_mem_ctrl_pkg;

    // Controller phase: clear sweep after reset, then normal request service.
    typedef enum logic [0:0] {
        HS_MEM_CTRL_INIT = 1'b0,
        HS_MEM_CTRL_RUN  = 1'b1
    } hs_mem_ctrl_state_e;

    // Index width needed to address 'depth' entries (at least one bit).
    function automatic int hs_mem_ctrl_addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hs_mem_ctrl_rsp_slice.sv
// One-entry valid/ready output register holding a RAM response {rdata, err}.
// A new entry may be loaded in the same cycle the current one is consumed,
// so a continuously-ready consumer sees one response per cycle.
module hs_mem_ctrl_rsp_slice
    import hs_mem_ctrl_pkg::*;
#(
    parameter type      DATA_TYPE  = logic [7:0],
    parameter DATA_TYPE INIT_VALUE = DATA_TYPE'('0)
) (
    input  logic     clk,
    input  logic     rst_n,
    // load side
    input  logic     in_valid,
    output logic     in_ready,
    input  DATA_TYPE in_rdata,
    input  logic     in_err,
    // drain side
    output logic     out_valid,
    input  logic     out_ready,
    output DATA_TYPE out_rdata,
    output logic     out_err
);

    logic     valid_q;
    logic     valid_d;
    DATA_TYPE rdata_q;
    DATA_TYPE rdata_d;
    logic     err_q;
    logic     err_d;
    logic     load;

    // Space is available when empty or when the held entry leaves this cycle.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Next-state: load wins over drain so valid stays high on a swap cycle;
    // data only changes on load, keeping a held response stable.
    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (load) begin
            valid_d = 1'b1;
            rdata_d = in_rdata;
            err_d   = in_err;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Response storage; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rdata_q <= INIT_VALUE;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: rtl/hs_mem_spram_ctrl.sv
// Initiator-side handshake front-end for a single-port RAM with asynchronous
// read. Clears the RAM after reset, then turns each accepted valid/ready
// request into one RAM access and one registered response. Writes return the
// old content because rdata is sampled in the same cycle the write is issued.
module hs_mem_spram_ctrl
    import hs_mem_ctrl_pkg::*;
#(
    parameter type      DATA_TYPE     = logic [7:0],
    parameter int       DATA_DEPTH    = 16,
    parameter DATA_TYPE INIT_VALUE    = DATA_TYPE'('0),
    parameter logic     INIT_ON_RESET = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    // request stream
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [hs_mem_ctrl_addr_width(DATA_DEPTH)-1:0] req_addr,
    input  DATA_TYPE                                      req_wdata,
    input  logic                                          req_wen,
    // response stream
    output logic                                          rsp_valid,
    input  logic                                          rsp_ready,
    output DATA_TYPE                                      rsp_rdata,
    output logic                                          rsp_err,
    // status
    output logic                                          init_busy,
    // RAM port
    output logic [hs_mem_ctrl_addr_width(DATA_DEPTH)-1:0] mem_addr,
    output DATA_TYPE                                      mem_wdata,
    output logic                                          mem_wen,
    input  DATA_TYPE                                      mem_rdata
);

    localparam int ADDR_WIDTH = hs_mem_ctrl_addr_width(DATA_DEPTH);

    // Last entry of the sweep, and the depth widened by one bit so that
    // non-power-of-two depths can be compared against any request address.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam hs_mem_ctrl_state_e    RESET_STATE = INIT_ON_RESET ? HS_MEM_CTRL_INIT
                                                                  : HS_MEM_CTRL_RUN;

    hs_mem_ctrl_state_e    state_q;
    hs_mem_ctrl_state_e    state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  init_busy_q;
    logic                  init_busy_d;

    logic                  run;
    logic                  in_range;
    logic                  accept;
    logic                  slice_in_ready;
    DATA_TYPE              rsp_rdata_in;
    logic                  rsp_err_in;

    assign run      = (state_q == HS_MEM_CTRL_RUN);
    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);

    // Requests are taken only in RUN and only when the response slot frees up.
    assign req_ready = run && slice_in_ready;
    assign accept    = req_valid && req_ready;

    // Sweep sequencing: one entry per cycle, then RUN for good.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == HS_MEM_CTRL_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = HS_MEM_CTRL_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
            end
        end
        init_busy_d = (state_d == HS_MEM_CTRL_INIT);
    end

    // Controller state; an asynchronous reset restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_busy_q <= INIT_ON_RESET;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign init_busy = init_busy_q;

    // RAM port steering: sweep writes during INIT, request pass-through in RUN
    // with writes gated by accept and range so idle or bad requests are inert.
    always_comb begin
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_wen   = 1'b0;
        if (state_q == HS_MEM_CTRL_INIT) begin
            mem_addr  = cnt_q;
            mem_wdata = INIT_VALUE;
            mem_wen   = 1'b1;
        end else begin
            mem_wen   = accept && req_wen && in_range;
        end
    end

    // Response payload captured in the accept cycle, before any write lands.
    always_comb begin
        rsp_rdata_in = in_range ? mem_rdata : INIT_VALUE;
        rsp_err_in   = !in_range;
    end

    hs_mem_ctrl_rsp_slice #(
        .DATA_TYPE  (DATA_TYPE),
        .INIT_VALUE (INIT_VALUE)
    ) u_rsp_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_ready  (slice_in_ready),
        .in_rdata  (rsp_rdata_in),
        .in_err    (rsp_err_in),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_rdata (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: tb/tb_hs_mem_spram_ctrl.sv
// Bench for hs_mem_spram_ctrl: two instances (16 entries, and 12 entries so
// that 4-bit addresses can fall out of range), each attached to a simple
// asynchronous-read RAM. Requests update an array reference model and push
// the expected response; per-instance monitors pop and compare on consume.
module tb_hs_mem_spram_ctrl;

    localparam logic [7:0] INIT0 = 8'hA5;
    localparam logic [7:0] INIT1 = 8'h3C;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][3:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      req_wen;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [1:0][7:0] rsp_rdata;
    logic [1:0]      rsp_err;
    logic [1:0]      init_busy;
    logic [1:0][3:0] mem_addr;
    logic [1:0][7:0] mem_wdata;
    logic [1:0]      mem_wen;
    logic [1:0][7:0] mem_rdata;

    logic [7:0] ram0 [16];
    logic [7:0] ram1 [16];
    logic [7:0] ref_mem [2][16];
    rsp_t       exp_q [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    hs_mem_spram_ctrl #(
        .DATA_TYPE(logic [7:0]), .DATA_DEPTH(16), .INIT_VALUE(INIT0), .INIT_ON_RESET(1'b1)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_wen(req_wen[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .init_busy(init_busy[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wen(mem_wen[0]),
        .mem_rdata(mem_rdata[0])
    );

    hs_mem_spram_ctrl #(
        .DATA_TYPE(logic [7:0]), .DATA_DEPTH(12), .INIT_VALUE(INIT1), .INIT_ON_RESET(1'b1)
    ) u_dut12 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_wen(req_wen[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .init_busy(init_busy[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wen(mem_wen[1]),
        .mem_rdata(mem_rdata[1])
    );

    // RAM macros: write at the clock edge, combinational read.
    always @(posedge clk) if (mem_wen[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    always @(posedge clk) if (mem_wen[1]) ram1[mem_addr[1]] <= mem_wdata[1];
    assign mem_rdata[0] = ram0[mem_addr[0]];
    assign mem_rdata[1] = ram1[mem_addr[1]];

    function automatic int depth_of(input int u);
        return (u == 0) ? 16 : 12;
    endfunction

    function automatic logic [7:0] init_of(input int u);
        return (u == 0) ? INIT0 : INIT1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // After a completed sweep every entry holds the init value.
    task automatic model_clear(input int u);
        for (int i = 0; i < 16; i++) ref_mem[u][i] = init_of(u);
    endtask

    // Called at a falling edge right after rst_n release: checks every sweep cycle.
    task automatic check_sweep(input int u);
        for (int k = 0; k < depth_of(u); k++) begin
            #1;
            chk($sformatf("sweep%0d_cyc%0d {busy,wen,addr,ready}", u, k),
                {init_busy[u], mem_wen[u], mem_addr[u], req_ready[u]},
                {1'b1, 1'b1, 4'(k), 1'b0});
            @(negedge clk);
        end
        #1;
        chk($sformatf("sweep%0d_done {busy,ready}", u),
            {init_busy[u], req_ready[u]}, {1'b0, 1'b1});
        @(negedge clk);
        model_clear(u);
    endtask

    // Drive one request from a falling edge and wait (bounded) for acceptance.
    task automatic issue(input int u, input logic wen, input logic [3:0] a,
                         input logic [7:0] d, input logic need_fast);
        int   waitc;
        logic inr;
        rsp_t e;
        waitc        = 0;
        req_valid[u] = 1'b1;
        req_wen[u]   = wen;
        req_addr[u]  = a;
        req_wdata[u] = d;
        #1;
        while (!req_ready[u] && waitc < 100) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!req_ready[u]) begin
            chk($sformatf("accept_timeout%0d", u), 32'(req_ready[u]), 32'd1);
            req_valid[u] = 1'b0;
            return;
        end
        inr = (int'(a) < depth_of(u));
        chk($sformatf("mem_wen%0d", u), 32'(mem_wen[u]), 32'(wen && inr));
        if (inr) chk($sformatf("mem_addr%0d", u), 32'(mem_addr[u]), 32'(a));
        if (need_fast) chk($sformatf("throughput%0d_stall", u), waitc, 0);
        e.rdata = inr ? ref_mem[u][a] : init_of(u);
        e.err   = !inr;
        exp_q[u].push_back(e);
        if (wen && inr) ref_mem[u][a] = d;
        $display("req%0d %s addr=%0d wdata=%02h", u, wen ? "WR" : "RD", a, d);
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    // Scoreboard monitors: one per instance, compare whenever a response is consumed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        always @(negedge clk) begin : mon_blk
            rsp_t e;
            #2;
            if (rst_n[gi] && rsp_valid[gi] && rsp_ready[gi]) begin
                if (exp_q[gi].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp%0d: got rdata=%02h err=%0b, required none",
                             gi, rsp_rdata[gi], rsp_err[gi]);
                end else begin
                    e = exp_q[gi].pop_front();
                    chk($sformatf("rsp%0d_rdata", gi), 32'(rsp_rdata[gi]), 32'(e.rdata));
                    chk($sformatf("rsp%0d_err", gi), 32'(rsp_err[gi]), 32'(e.err));
                    $display("rsp%0d rdata=%02h err=%0b (exp %02h/%0b)",
                             gi, rsp_rdata[gi], rsp_err[gi], e.rdata, e.err);
                end
            end
        end
    end

    initial begin : main
        logic [7:0] held;
        for (int i = 0; i < 16; i++) begin
            ram0[i] = 8'($urandom);
            ram1[i] = 8'($urandom);
        end
        rst_n     = 2'b00;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset%0d {valid,rdata,err,busy,ready}", u),
                {rsp_valid[u], rsp_rdata[u], rsp_err[u], init_busy[u], req_ready[u]},
                {1'b0, init_of(u), 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst_n = 2'b11;
        fork
            check_sweep(0);
            check_sweep(1);
        join

        // Every entry reads back as the init value after the sweep.
        for (int a = 0; a < 16; a++) issue(0, 1'b0, 4'(a), 8'h00, 1'b0);
        // Write returns old content; following read sees new data.
        issue(0, 1'b1, 4'd3, 8'h5C, 1'b0);
        issue(0, 1'b0, 4'd3, 8'h00, 1'b0);

        // Out-of-range write and read on the 12-entry instance.
        issue(1, 1'b1, 4'd13, 8'hFF, 1'b0);
        issue(1, 1'b0, 4'd13, 8'h00, 1'b0);
        issue(1, 1'b1, 4'd11, 8'h77, 1'b0);
        issue(1, 1'b0, 4'd11, 8'h00, 1'b0);

        // Backpressure: held response stays put and blocks new requests.
        rsp_ready[0] = 1'b0;
        held = ref_mem[0][3];
        issue(0, 1'b0, 4'd3, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("hold_cyc%0d {valid,ready,rdata}", c),
                {rsp_valid[0], req_ready[0], rsp_rdata[0]}, {1'b1, 1'b0, held});
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        issue(0, 1'b1, 4'd7, 8'h9E, 1'b1);
        #1;
        chk("swap_valid_stays", 32'(rsp_valid[0]), 32'd1);
        @(negedge clk);

        // Streaming random traffic at full rate on both instances.
        for (int i = 0; i < 64; i++)
            issue(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
        for (int i = 0; i < 40; i++)
            issue(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
        repeat (2) @(negedge clk);

        // Reset with a response pending: discarded immediately.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 4'd7, 8'h00, 1'b0);
        #1;
        chk("pending_before_reset", 32'(rsp_valid[0]), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("async_reset_pending {valid,rdata,err,busy,ready}",
            {rsp_valid[0], rsp_rdata[0], rsp_err[0], init_busy[0], req_ready[0]},
            {1'b0, INIT0, 1'b0, 1'b1, 1'b0});
        exp_q[0].delete();
        rsp_ready[0] = 1'b1;
        @(negedge clk);

        // Reset asserted at sweep cycle 7, then a full restart from entry 0.
        rst_n[0] = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        chk("midsweep_addr_before_reset", 32'(mem_addr[0]), 32'd7);
        #1;
        rst_n[0] = 1'b0;
        #1;
        chk("midsweep_reset {valid,busy,addr}",
            {rsp_valid[0], init_busy[0], mem_addr[0]}, {1'b0, 1'b1, 4'd0});
        @(negedge clk);
        rst_n[0] = 1'b1;
        check_sweep(0);
        for (int a = 0; a < 16; a += 5) issue(0, 1'b0, 4'(a), 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        chk("drain0_left", exp_q[0].size(), 0);
        chk("drain1_left", exp_q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
